// File: rtl/aes_sbox_pkg.sv
// Shared constants and FSM encoding for the masked S-box BRAM feeders.
// Widths here are common to every BRAM pair in the 5-serial datapath.
package aes_sbox_pkg;

    localparam int NBYTES   = 16;
    localparam int BRAM_LAT = 2;
    localparam int SHARE_W  = 8;
    localparam int RND_W    = 2;
    localparam int ADDR_W   = 10;
    localparam int IDX_W    = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    // BRAM address: fresh mask-select bits on top, one share byte below.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [RND_W-1:0]   rnd,
        input logic [SHARE_W-1:0] share
    );
        return {rnd, share};
    endfunction

endpackage

// File: rtl/sbox_lat_pipe.sv
// Valid + byte-index shift register that shadows the fixed BRAM read latency.
// Carries only control; share data never enters this pipe.
module sbox_lat_pipe #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             tail_valid,
    output logic [IDX_W-1:0] tail_idx
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            idx <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign tail_valid = vld[DEPTH-1];
    assign tail_idx   = idx[DEPTH-1];

endmodule

// File: rtl/sbox_bram_feeder.sv
// Feeds one masked S-box BRAM pair with a 16-byte serial round and re-aligns
// DOA/DOB into a valid-tagged, index-tagged output pair.
module sbox_bram_feeder
    import aes_sbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHARE_W-1:0] in_share0,
    input  logic [SHARE_W-1:0] in_share1,
    input  logic [2*RND_W-1:0] in_rnd,
    output logic [ADDR_W-1:0]  bram_addra,
    output logic [ADDR_W-1:0]  bram_addrb,
    output logic               bram_en,
    output logic               bram_rst,
    input  logic [SHARE_W-1:0] bram_doa,
    input  logic [SHARE_W-1:0] bram_dob,
    output logic               out_valid,
    output logic [SHARE_W-1:0] out_share0,
    output logic [SHARE_W-1:0] out_share1,
    output logic [IDX_W-1:0]   byte_idx,
    output logic               round_done
);

    feeder_state_e    state;
    logic [IDX_W-1:0] in_cnt;
    logic             accept;
    logic             tail_valid;
    logic [IDX_W-1:0] tail_idx;
    logic             last_out;

    // Input handshake: a byte transfers on any cycle with in_valid && in_ready.
    // The output side has no ready; the BRAM and this block never stall.
    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign bram_en  = (state != IDLE);
    assign bram_rst = rst;
    assign last_out = tail_valid && (tail_idx == IDX_W'(NBYTES - 1));

    sbox_lat_pipe #(
        .DEPTH (BRAM_LAT + 1),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_idx     (in_cnt),
        .tail_valid (tail_valid),
        .tail_idx   (tail_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_cnt     <= '0;
            round_done <= 1'b0;
            out_valid  <= 1'b0;
            byte_idx   <= '0;
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        in_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + IDX_W'(1);
                        if (in_cnt == IDX_W'(NBYTES - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_out) begin
                        state      <= IDLE;
                        round_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            out_valid <= tail_valid;
            if (tail_valid) begin
                byte_idx <= tail_idx;
            end
        end
    end

    // Share 0 path: its own address and result registers, never muxed with share 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_addra <= '0;
            out_share0 <= '0;
        end else begin
            if (accept) begin
                bram_addra <= make_addr(in_rnd[RND_W-1:0], in_share0);
            end
            if (tail_valid) begin
                out_share0 <= bram_doa;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_addrb <= '0;
            out_share1 <= '0;
        end else begin
            if (accept) begin
                bram_addrb <= make_addr(in_rnd[2*RND_W-1:RND_W], in_share1);
            end
            if (tail_valid) begin
                out_share1 <= bram_dob;
            end
        end
    end

endmodule

// File: tb/tb_sbox_bram_feeder.sv
// Randomized scoreboard bench for sbox_bram_feeder with a behavioural
// dual-port registered BRAM holding two random tables.
module tb_sbox_bram_feeder;
    import aes_sbox_pkg::*;

    localparam int W = 1 + IDX_W + 2 * SHARE_W;

    logic               clk;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [SHARE_W-1:0] in_share0;
    logic [SHARE_W-1:0] in_share1;
    logic [3:0]         in_rnd;
    logic [ADDR_W-1:0]  bram_addra;
    logic [ADDR_W-1:0]  bram_addrb;
    logic               bram_en;
    logic               bram_rst;
    logic [SHARE_W-1:0] bram_doa;
    logic [SHARE_W-1:0] bram_dob;
    logic               out_valid;
    logic [SHARE_W-1:0] out_share0;
    logic [SHARE_W-1:0] out_share1;
    logic [IDX_W-1:0]   byte_idx;
    logic               round_done;

    sbox_bram_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_share0  (in_share0),
        .in_share1  (in_share1),
        .in_rnd     (in_rnd),
        .bram_addra (bram_addra),
        .bram_addrb (bram_addrb),
        .bram_en    (bram_en),
        .bram_rst   (bram_rst),
        .bram_doa   (bram_doa),
        .bram_dob   (bram_dob),
        .out_valid  (out_valid),
        .out_share0 (out_share0),
        .out_share1 (out_share1),
        .byte_idx   (byte_idx),
        .round_done (round_done)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model: array read + output register ----------------
    logic [7:0] tab_a [1024];
    logic [7:0] tab_b [1024];
    logic [7:0] a_r1, a_r2, b_r1, b_r2;
    always @(posedge clk) begin
        if (bram_rst) begin
            a_r1 <= '0; a_r2 <= '0; b_r1 <= '0; b_r2 <= '0;
        end else if (bram_en) begin
            a_r1 <= tab_a[bram_addra];
            a_r2 <= a_r1;
            b_r1 <= tab_b[bram_addrb];
            b_r2 <= b_r1;
        end
    end
    assign bram_doa = a_r2;
    assign bram_dob = b_r2;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];

    bit          m_running  = 1'b0;
    int          m_cnt      = 0;
    int          m_idle_cyc = 0;
    logic [9:0]  m_addra    = '0;
    logic [9:0]  m_addrb    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic st, input logic v, input logic [7:0] s0,
                               input logic [7:0] s1, input logic [3:0] r);
        logic [9:0] aa;
        logic [9:0] bb;
        logic       last;
        start     = st;
        in_valid  = v;
        in_share0 = s0;
        in_share1 = s1;
        in_rnd    = r;
        @(negedge clk);
        chk("in_ready", in_ready, m_running);
        chk("bram_en", bram_en, (m_running || cyc < m_idle_cyc));
        chk("bram_rst", bram_rst, 0);
        chk("addra", bram_addra, m_addra);
        chk("addrb", bram_addrb, m_addrb);
        if (v && m_running) begin
            aa   = {r[1:0], s0};
            bb   = {r[3:2], s1};
            last = (m_cnt == NBYTES - 1);
            exp_q.push_back({last, IDX_W'(m_cnt), tab_a[aa], tab_b[bb]});
            due_q.push_back(cyc + BRAM_LAT + 2);
            m_addra = aa;
            m_addrb = bb;
            m_cnt++;
            if (m_cnt == NBYTES) begin
                m_running  = 1'b0;
                m_idle_cyc = cyc + BRAM_LAT + 2;
            end
        end else if (st && !m_running && cyc >= m_idle_cyc) begin
            m_running = 1'b1;
            m_cnt     = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic st, input logic v);
        drive_cycle(st, v, 8'($urandom), 8'($urandom), 4'($urandom));
    endtask

    task automatic wait_idle();
        while (cyc <= m_idle_cyc) drive_rand(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b1;
        in_share0 = 8'($urandom);
        in_share1 = 8'($urandom);
        in_rnd    = 4'($urandom);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_share0", out_share0, 0);
            chk("rst_out_share1", out_share1, 0);
            chk("rst_byte_idx", byte_idx, 0);
            chk("rst_round_done", round_done, 0);
            chk("rst_addra", bram_addra, 0);
            chk("rst_addrb", bram_addrb, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_bram_en", bram_en, 0);
            chk("rst_bram_rst", bram_rst, 1);
        end
        exp_q.delete();
        due_q.delete();
        m_running  = 1'b0;
        m_cnt      = 0;
        m_idle_cyc = 0;
        m_addra    = '0;
        m_addrb    = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_e;
    int           mon_due;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got idx %0h with no pending byte (cycle %0d)", byte_idx, cyc);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    chk("out_latency", cyc, mon_due);
                    chk("byte_idx", byte_idx, mon_e[2*SHARE_W +: IDX_W]);
                    chk("out_share0", out_share0, mon_e[SHARE_W +: SHARE_W]);
                    chk("out_share1", out_share1, mon_e[0 +: SHARE_W]);
                    chk("round_done", round_done, mon_e[W-1]);
                end
            end else begin
                chk("round_done_quiet", round_done, 0);
                if (due_q.size() != 0 && due_q[0] <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_out: got no out_valid expected byte due at cycle %0d (cycle %0d)", due_q[0], cyc);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int total;
        int k;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_share0 = '0; in_share1 = '0; in_rnd = '0;
        for (int i = 0; i < 1024; i++) begin
            tab_a[i] = 8'($urandom);
            tab_b[i] = 8'($urandom);
        end

        do_reset(3);
        repeat (2) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);

        // Full round, no bubbles
        drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b1, 8'(i), 8'(255 - i), 4'b1001);
        wait_idle();

        // Bubbles: in_valid alternates
        drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
        k = 0;
        while (m_running) begin
            drive_rand(1'b0, (k % 2) == 0);
            k++;
        end
        wait_idle();

        // Reset after byte 7, then a clean round
        drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 8; i++) drive_rand(1'b0, 1'b1);
        do_reset(1);
        repeat (3) drive_rand(1'b0, 1'b0);
        drive_rand(1'b1, 1'b0);
        while (m_running) drive_rand(1'b0, 1'b1);
        wait_idle();

        // Start misuse in RUN and DRAIN, then start right after round_done
        drive_rand(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) drive_rand((i % 3) == 0, 1'b1);
        drive_rand(1'b1, 1'b0);
        drive_rand(1'b1, 1'b0);
        while (cyc <= m_idle_cyc) drive_rand(1'b0, 1'b0);
        drive_rand(1'b1, 1'b0);
        chk("start_after_done", m_running, 1);
        while (m_running) drive_rand(1'b0, 1'b1);
        wait_idle();

        // Random rounds, about 1000 bytes
        total = 0;
        while (total < 1000) begin
            repeat ($urandom_range(0, 2)) drive_rand(1'b0, 1'($urandom_range(0, 1)));
            drive_rand(1'b1, 1'($urandom_range(0, 1)));
            while (m_running) drive_rand(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
            total += NBYTES;
            while (cyc <= m_idle_cyc)
                drive_rand((cyc != m_idle_cyc) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (4) drive_rand(1'b0, 1'b0);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL timeout: got no end of stimulus expected finish before 1000000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sbox_bram_feeder.md
Name: sbox_bram_feeder

Overview:
- Upstream feeder and result collector for one dual-port masked S-box BRAM pair, e.g. the x26_x49 table, in the 5-serial AES encryption datapath.
- Accepts one two-share masked state byte per cycle for a serial round of 16 bytes.
- Forms the two 10-bit BRAM addresses from share byte plus fresh-mask select bits, and drives the BRAM enable.
- Tracks the registered BRAM read latency and re-aligns DOA/DOB into a valid-tagged output pair; pulses round_done once all 16 results have left.

Parameters:
- NBYTES, 16, bytes per serial round; counter width is clog2(NBYTES).
- BRAM_LAT, 2, cycles from address at BRAM pins to DOA/DOB valid (array read plus DOx_REG stage).

Ports:
- clk  in  1  single system clock; also drives both BRAM ports.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a round.
- in_valid  in  1  input byte present.
- in_ready  out  1  feeder accepts a byte this cycle.
- in_share0  in  8  masked byte, share 0.
- in_share1  in  8  masked byte, share 1.
- in_rnd  in  4  fresh mask-select bits: [1:0] go to port A, [3:2] go to port B.
- bram_addra  out  10  BRAM ADDRA.
- bram_addrb  out  10  BRAM ADDRB.
- bram_en  out  1  BRAM EN: drives ENA, ENB, REGCEA, REGCEB.
- bram_rst  out  1  BRAM RST, equal to rst.
- bram_doa  in  8  BRAM DOA.
- bram_dob  in  8  BRAM DOB.
- out_valid  out  1  output pair valid.
- out_share0  out  8  registered DOA.
- out_share1  out  8  registered DOB.
- byte_idx  out  4  index of the byte on the output.
- round_done  out  1  one-cycle pulse after the last output.

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous, active-high, on rst.
  - On rst: state IDLE, counters 0, valid pipe cleared, every registered output 0 (addresses, out_*, out_valid, byte_idx, round_done).
  - in_ready and bram_en are 0 in IDLE.
  - rst mid-round aborts the round, with no round_done and no out_valid thereafter.
  - rst has priority over every other input.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the cycle the NBYTES-th byte is accepted.
  - DRAIN -> IDLE when the last result is emitted; round_done=1 in that same cycle.
  - start in RUN or DRAIN is ignored.
- Accept:
  - in_ready = (state==RUN).
  - A byte is accepted when in_valid && in_ready.
  - in_valid=0 in RUN inserts a bubble; the round length still counts only accepted bytes.
- Address stage, registered, 1 cycle:
  - On accept: bram_addra <= {in_rnd[1:0], in_share0}; bram_addrb <= {in_rnd[3:2], in_share1}.
  - On a non-accept cycle the addresses hold their value.
- Enable:
  - bram_en = 1 whenever state != IDLE.
  - The BRAM never stalls; data is tracked by a BRAM_LAT+1 deep valid/index shift register.
- Output stage:
  - When the valid pipe tail is set: out_share0 <= bram_doa, out_share1 <= bram_dob, byte_idx <= tail index, out_valid <= 1.
  - Otherwise out_valid <= 0 and data holds.
  - End-to-end latency from accept edge to out_valid = BRAM_LAT + 2 cycles (4 at default).
- Ordering: outputs leave in acceptance order with byte_idx 0..NBYTES-1. There is no backpressure on the output.
- Boundary cases:
  - Accept with in_valid on the NBYTES-th byte: in_ready drops the next cycle.
  - round_done coincides with out_valid for byte_idx = NBYTES-1.
  - A new start is honoured only when back in IDLE, the cycle after round_done.
- Masking requirements:
  - share0 and share1 are never combined in any register or mux in this block.
  - Each share path is registered independently (glitch/first-order separation).

Decomposition:
- Shared package aes_sbox_pkg holds:
  - NBYTES.
  - BRAM_LAT.
  - Address field widths: SHARE_W=8, RND_W=2, ADDR_W=10.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One natural sub-module, sbox_lat_pipe: the parameterised valid + index shift register. It is reused by the sibling BRAM pairs.

Test Plan:
- Reset: rst high 3 cycles with in_valid=1 -> all outputs 0, in_ready=0, bram_en=0.
- Full round, no bubbles: start, then 16 consecutive bytes with share0=i, share1=0xFF-i, in_rnd=4'b1001.
  - Cycle after each accept: addra={2'b01,i}, addrb={2'b10,0xFF-i}.
  - With a BRAM behavioural model, out_valid for 16 cycles beginning 4 cycles after the first accept; byte_idx 0..15.
  - round_done together with idx 15.
- Bubbles: in_valid toggles 1,0,1,0 over the round -> exactly 16 outputs, in order, each 4 cycles after its accept; addresses hold during the gaps.
- Reset mid-round: rst asserted after byte 7 is accepted -> next cycle everything is 0, no round_done. A following start completes a clean 16-byte round.
- Start misuse: start pulsed during RUN and DRAIN -> ignored, count unaffected. Start in the cycle right after round_done -> new round begins.
- Share separation: random shares over 1000 bytes -> out_share0 = T_A[addra] and out_share1 = T_B[addrb] per byte, checked against the BRAM model.
